// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// Funct codes, ALU controls and datapath mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/main_control_fsm_if.sv
// Control/decode bundle between main_control_fsm (master) and the datapath (slave).
interface main_control_fsm_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       IllegalOp;

  modport master (
    input  Opcode, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, IllegalOp
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, IllegalOp
  );
endinterface

// File: rtl/main_control_fsm_alu_decoder.sv
// Combinational ALU decoder: (ALUOp, Funct) -> ALUControl. Unknown Funct adds.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control FSM with Moore control word; PCEn in BRANCH follows Zero.
// Define BNE_EN to add bne (opcode 000101) through a branch-type flag latched in DECODE.
module main_control_fsm
  import mips_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  main_control_fsm_if.master    bus
);

  state_t     state_q, state_d;
  logic       pc_write, branch, branch_cond, illegal;
  logic [1:0] alu_op;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

`ifdef BNE_EN
  logic bne_q, bne_d;

  always_comb begin
    bne_d = bne_q;
    if (state_q == S_DECODE) bne_d = (bus.Opcode == OP_BNE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) bne_q <= 1'b0;
    else      bne_q <= bne_d;
  end

  assign branch_cond = bne_q ? ~bus.Zero : bus.Zero;
`else
  assign branch_cond = bus.Zero;
`endif

  always_comb begin
    state_d        = S_FETCH;
    illegal        = 1'b0;
    pc_write       = 1'b0;
    branch         = 1'b0;
    alu_op         = ALUOP_ADD;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_B;
    bus.PCSrc      = PC_ALURES;
    case (state_q)
      S_FETCH: begin
        bus.IRWrite = 1'b1;
        pc_write    = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcB = SRCB_IMM_SH;
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.IorD = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_RTYPEEX: begin
        bus.ALUSrcA = 1'b1;
        alu_op      = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        alu_op      = ALUOP_SUB;
        bus.PCSrc   = PC_ALUOUT;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
      S_JUMP: begin
        bus.PCSrc = PC_JUMP;
        pc_write  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.PCEn      = pc_write | (branch & branch_cond);
  assign bus.IllegalOp = illegal;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (bus.Funct),
    .alu_control (bus.ALUControl)
  );

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: per-cycle control words against an instruction-class
// model (instruction kind + cycle index within the instruction). Honours BNE_EN.
module tb_main_control_fsm;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  wire [15:0] obs = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                     bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                     bus.PCSrc, bus.PCEn, bus.IllegalOp};

`ifdef BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%04h exp=%04h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010) ||
           (BNE_ON && op == 6'b000101);
  endfunction

  function automatic int cpi(input logic [5:0] op);
    if (op == 6'b100011) return 5;
    if (op == 6'b101011 || op == 6'b000000 || op == 6'b001000) return 4;
    if (op == 6'b000100 || op == 6'b000010) return 3;
    if (BNE_ON && op == 6'b000101) return 3;
    return 2;
  endfunction

  // Expected control word for cycle s (0 = fetch) of an instruction.
  function automatic logic [15:0] exp_word(input logic [5:0] op, input logic [5:0] fn,
                                           input logic z, input int s);
    logic iord, mw, irw, rdst, m2r, rw, sa, pcen, ill;
    logic [1:0] sb, pcs;
    logic [2:0] ac;
    {iord, mw, irw, rdst, m2r, rw, sa, pcen, ill} = '0;
    sb = 2'b00; pcs = 2'b00; ac = 3'b010;
    if (s == 0) begin
      irw = 1; sb = 2'b01; pcen = 1;
    end else if (s == 1) begin
      sb = 2'b11; ill = !is_legal(op);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      if (s == 2) begin sa = 1; sb = 2'b10; end
      else if (op == 6'b101011) begin iord = 1; mw = 1; end
      else if (s == 3) iord = 1;
      else begin rw = 1; m2r = 1; end
    end else if (op == 6'b000000) begin
      if (s == 2) begin sa = 1; ac = funct_alu(fn); end
      else begin rdst = 1; rw = 1; end
    end else if (op == 6'b001000) begin
      if (s == 2) begin sa = 1; sb = 2'b10; end
      else rw = 1;
    end else if (op == 6'b000100 || op == 6'b000101) begin
      sa = 1; ac = 3'b110; pcs = 2'b01;
      pcen = (op == 6'b000101) ? !z : z;
    end else if (op == 6'b000010) begin
      pcs = 2'b10; pcen = 1;
    end
    return {iord, mw, irw, rdst, m2r, rw, sa, sb, ac, pcs, pcen, ill};
  endfunction

  // zsel: 0/1 fixed Zero, 2 random per cycle. Entered just after a posedge in FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int zsel);
    logic z;
    for (int s = 0; s < cpi(op); s++) begin
      z = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      bus.Opcode = op;
      bus.Funct  = fn;
      bus.Zero   = z;
      #1;
      chk($sformatf("%s_op%02h_c%0d", name, op, s), obs, exp_word(op, fn, z, s));
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [15:0] FETCH_WORD = 16'b0010_0000_1010_0010;

  initial begin
    logic [5:0] op, fn;
    rst_n      = 1'b0;
    bus.Opcode = 6'b100011;
    bus.Funct  = 6'b0;
    bus.Zero   = 1'b0;
    #12;
    chk("reset_word", obs, FETCH_WORD);
    chk("reset_model", obs, exp_word(6'b100011, 6'b0, 1'b0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("lw", 6'b100011, 6'b0, 2);
    run_instr("rtype_slt", 6'b000000, 6'b101010, 2);
    run_instr("beq_z1", 6'b000100, 6'b0, 1);
    run_instr("beq_z0", 6'b000100, 6'b0, 0);
    run_instr("illegal", 6'b111111, 6'b0, 2);
    run_instr("bne_z0", 6'b000101, 6'b0, 0);
    run_instr("bne_z1", 6'b000101, 6'b0, 1);
    run_instr("j", 6'b000010, 6'b0, 2);
    run_instr("addi", 6'b001000, 6'b0, 2);
    run_instr("sw", 6'b101011, 6'b0, 2);
    run_instr("rtype_unk", 6'b000000, 6'b111111, 2);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 8))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000101;
        5: op = 6'b001000;
        6: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        4: fn = 6'b101010;
        default: fn = 6'($urandom);
      endcase
      run_instr("rand", op, fn, 2);
    end

    // Abandon an lw in MEMRD with an asynchronous reset.
    bus.Opcode = 6'b100011;
    bus.Funct  = 6'b0;
    bus.Zero   = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("memrd_before_reset", obs, exp_word(6'b100011, 6'b0, 1'b0, 3));
    rst_n = 1'b0;
    #1;
    chk("reset_mid_memrd", obs, FETCH_WORD);
    #2;
    rst_n = 1'b1;
    run_instr("after_reset_addi", 6'b001000, 6'b0, 2);
    run_instr("after_reset_beq", 6'b000100, 6'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
